// File: rtl/inmp441_rx.sv
// I2S master receiver for a 24-bit INMP441-style microphone: generates sck/ws,
// captures the left slot MSB-first and hands samples out through a 1-deep valid/ready register.
module inmp441_rx #(
  parameter int CLK_DIV  = 8,
  parameter int SAMPLE_W = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  output logic                       sck,
  output logic                       ws,
  output logic                       lr,
  input  logic                       sd,
  output logic signed [SAMPLE_W-1:0] sample_data,
  output logic                       sample_valid,
  input  logic                       sample_ready,
  output logic                       overrun
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
  localparam logic [5:0]       LAST_BIT = 6'(SAMPLE_W - 1);
  localparam logic [5:0]       BIT_IDLE = 6'd63;
  localparam logic [5:0]       BIT_WS_R = 6'd32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [5:0]            bit_cnt_q, bit_cnt_d;
  logic                  sck_q, sck_d;
  logic                  ws_q, ws_d;
  logic [SAMPLE_W-1:0]   shift_q, shift_d;
  logic                  done_q, done_d;
  logic [SAMPLE_W-1:0]   data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      bit_cnt_q <= BIT_IDLE;
      sck_q     <= 1'b0;
      ws_q      <= 1'b1;
      shift_q   <= '0;
      done_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sck_q     <= sck_d;
      ws_q      <= ws_d;
      shift_q   <= shift_d;
      done_q    <= done_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    sck_d     = sck_q;
    ws_d      = ws_q;
    shift_d   = shift_q;
    done_d    = 1'b0;
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    case (state_q)
      IDLE: begin
        sck_d     = 1'b0;
        ws_d      = 1'b1;
        div_cnt_d = '0;
        bit_cnt_d = BIT_IDLE;
        shift_d   = '0;
        if (en) begin
          state_d   = RUN;
          overrun_d = 1'b0;
        end
      end
      RUN: begin
        if (!en) begin
          // Abort: the partially shifted word is dropped, the output register is left alone.
          state_d   = IDLE;
          sck_d     = 1'b0;
          ws_d      = 1'b1;
          div_cnt_d = '0;
          bit_cnt_d = BIT_IDLE;
          shift_d   = '0;
        end else if (div_cnt_q == DIV_MAX) begin
          div_cnt_d = '0;
          sck_d     = ~sck_q;
          if (sck_q) begin
            // Falling sck edge: advance the slot counter and sample sd in the left slot.
            bit_cnt_d = bit_cnt_q + 6'd1;
            if (bit_cnt_d == 6'd0) ws_d = 1'b0;
            if (bit_cnt_d == BIT_WS_R) ws_d = 1'b1;
            if (bit_cnt_q <= LAST_BIT) shift_d = {shift_q[SAMPLE_W-2:0], sd};
            done_d = (bit_cnt_q == LAST_BIT);
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (done_q) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      if (valid_q && !sample_ready) overrun_d = 1'b1;
    end else if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end
  end

  assign sck          = sck_q;
  assign ws           = ws_q;
  assign lr           = 1'b0;
  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule

// File: doc/inmp441_rx.md
Name: inmp441_rx

Overview:
- Synthesizable I2S master receiver for an INMP441-type 24-bit MEMS microphone; sits directly upstream of the note-recognition datapath.
- Generates sck and ws from the system clock and drives lr low (left channel).
- Deserializes sd MSB-first into 24-bit two's-complement samples, one per ws frame.
- Delivers samples through a 1-deep valid/ready output register with a sticky overrun flag.

Parameters:
- CLK_DIV, 8, clk cycles per sck half-period (≥2); 50 MHz clk gives a 320 ns sck.
- SAMPLE_W, 24, sample width in bits.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- en  input  1  run enable
- sck  output  1  I2S bit clock to the microphone
- ws  output  1  word select; 0 = left slot, 1 = right slot
- lr  output  1  microphone channel select, constant 0
- sd  input  1  serial data from the microphone; Z/X outside bits 0..23
- sample_data  output  SAMPLE_W  last captured sample, signed
- sample_valid  output  1  sample_data holds an unconsumed sample
- sample_ready  input  1  consumer accepts the sample
- overrun  output  1  sticky: a sample was overwritten before it was consumed

Behaviour:
- Reset (async, immediate, no clk edge needed): sck=0, ws=1, lr=0, sample_data=0, sample_valid=0, overrun=0, div_cnt=0, bit_cnt=63, state IDLE. All outputs are registered.
- States:
  - IDLE: sck held 0, ws held 1, counters held at reset values.
  - RUN.
  - IDLE→RUN on a clk edge with en=1. That edge is cycle 0.
  - RUN→IDLE on any clk edge with en=0. The next cycle has sck=0 and ws=1, the partial shift register is discarded, and the pending sample and sample_valid are kept.
- Divider: in RUN, sck toggles at cycles CLK_DIV, 2·CLK_DIV, 3·CLK_DIV, …, giving CLK_DIV clk high and CLK_DIV clk low per sck period.
- Fall event: the clk edge on which sck goes 1→0. At each fall event:
  - bit_cnt ← (bit_cnt+1) mod 64.
  - If new bit_cnt=0, then ws←0; if new bit_cnt=32, then ws←1.
  - If old bit_cnt is in 0..23, shift sd into the LSB of the shift register (MSB arrives first). sd is never used at any other time.
- Frame: 64 sck per frame with ws low for 32 sck. The first fall event after enable (cycle 2·CLK_DIV) drops ws. The MSB is sampled at cycle 4·CLK_DIV and the LSB at cycle 50·CLK_DIV.
- Completion: on the clk edge after the LSB-shift edge, sample_data ← shift register and sample_valid ← 1. First valid is at cycle 50·CLK_DIV+1; later valids follow every 128·CLK_DIV cycles.
- Handshake: sample_valid stays 1 until an edge with sample_ready=1, after which it goes 0, unless a completion occurs on that same edge.
- Completion with sample_valid=1 and sample_ready=0: the new word overwrites sample_data, sample_valid stays 1, overrun←1.
- Completion on the same edge as sample_ready=1: the new word is loaded, sample_valid stays 1, overrun is unchanged.
- sample_ready while sample_valid=0 is ignored.
- overrun clears only on rst or on IDLE→RUN.
- Right slot (bit_cnt 32..63): sck and ws are still generated; no capture takes place.

Test Plan (CLK_DIV=8, clk period 20 ns, bench I2S slave drives sd on sck rise +10 ns, MSB on the first sck rise after ws falls):
- Waveform: en=1 → sck high/low 8 clk each; ws falls at cycle 16 and rises after 32 sck; ws period 1024 clk; lr=0 throughout.
- Slave sends 24'hA5C3F1, sample_ready=1 → sample_data=24'hA5C3F1 with sample_valid=1 for exactly cycle 401; next word 24'hFFFFFC → valid at cycle 1425 with data 24'hFFFFFC.
- sample_ready=0 across two frames (0x000123, then 0x7FFFFF) → sample_valid stays 1, overrun=1 at cycle 1425, sample_data=24'h7FFFFF.
- Valid pending and sample_ready=1 exactly on the cycle-1425 completion edge → sample_valid stays 1 with the new data, overrun=0.
- en=0 after 10 bits shifted → next cycle sck=0 and ws=1, no valid produced; en=1 again → first valid 401 cycles later with a correct full word, overrun=0.
- rst pulsed mid-frame between clk edges → all outputs take reset values immediately; after release and en=1, timing restarts from cycle 0.
